// File: rtl/vout_stream_buffer.sv
// Output pixel buffer between the frame-buffer read path and the video timing generator.
// Optional build macro VOUT_STREAM_UNDERFLOW_CNT_EN adds a saturating per-frame underflow counter.
module vout_stream_buffer #(
   parameter int                    DATA_WIDTH   = 24,
   parameter int                    ADDR_WIDTH   = 9,
   parameter int                    AFULL_MARGIN = 60,
   parameter int                    PREFILL      = 32,
   parameter logic [DATA_WIDTH-1:0] FILL_COLOR   = 24'h108080
) (
   input  logic                  pixel_clk,
   input  logic                  rst_n,
   input  logic                  vs,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  pixel_rd_req,
   output logic [DATA_WIDTH-1:0] pixel_data,
   output logic                  pixel_de,
   output logic [ADDR_WIDTH:0]   fifo_level,
   output logic                  frame_ready,
   output logic                  underflow,
`ifdef VOUT_STREAM_UNDERFLOW_CNT_EN
   output logic [15:0]           underflow_cnt,
`endif
   output logic [1:0]            dbg_state
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] THRESH_LVL  = (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN);
   localparam logic [ADDR_WIDTH:0] PREFILL_LVL = (ADDR_WIDTH+1)'(PREFILL);

   typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_FILL, ST_RUN} state_t;

   state_t                state_q, state_d;
   logic                  vs_d0_q;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  served_q, de_q, frame_ready_q;
   logic                  underflow_q, underflow_d;
   logic                  frame_start, active, wr_en, rd_en, starve;

   assign frame_start = vs & ~vs_d0_q;

   // State register
   always_ff @(posedge pixel_clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; a new frame start overrides every other transition
   always_comb begin
      state_d = state_q;
      if (frame_start) begin
         state_d = ST_FLUSH;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_FLUSH: state_d = ST_FILL;
            ST_FILL:  if (level_q >= PREFILL_LVL) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Output/handshake decode from registered state and level.
   // in_valid/in_ready: a word transfers on a cycle where both are high; the
   // producer must hold in_data stable while in_valid is high and in_ready low.
   always_comb begin
      active   = (state_q == ST_FILL) || (state_q == ST_RUN);
      in_ready = active && (level_q < THRESH_LVL);
      wr_en    = in_valid && in_ready;
      rd_en    = pixel_rd_req && active && (level_q != '0);
      starve   = pixel_rd_req && (state_q == ST_RUN) && (level_q == '0);
   end

   // Pointer/level bookkeeping; the frame-start cycle still transfers, then clears
   always_comb begin
      wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(wr_en);
      rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(rd_en);
      level_d     = level_q;
      underflow_d = underflow_q | starve;
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      if (frame_start) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
         vs_d0_q       <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         served_q      <= 1'b0;
         de_q          <= 1'b0;
         frame_ready_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         vs_d0_q       <= vs;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         served_q      <= rd_en;
         de_q          <= pixel_rd_req;
         frame_ready_q <= (state_d == ST_RUN);
         underflow_q   <= underflow_d;
      end
   end

   // Simple dual-port RAM with registered read
   always_ff @(posedge pixel_clk) begin
      if (wr_en) mem[wr_ptr_q] <= in_data;
      if (rd_en) rd_data_q     <= mem[rd_ptr_q];
   end

`ifdef VOUT_STREAM_UNDERFLOW_CNT_EN
   logic [15:0] ucnt_q, ucnt_d;
   always_comb begin
      ucnt_d = ucnt_q;
      if (frame_start)                      ucnt_d = '0;
      else if (starve && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
   end
   always_ff @(posedge pixel_clk) begin
      if (!rst_n) ucnt_q <= '0;
      else        ucnt_q <= ucnt_d;
   end
   assign underflow_cnt = ucnt_q;
`endif

   assign pixel_data  = served_q ? rd_data_q : FILL_COLOR;
   assign pixel_de    = de_q;
   assign fifo_level  = level_q;
   assign frame_ready = frame_ready_q;
   assign underflow   = underflow_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_vout_stream_buffer.sv
// Self-checking bench for vout_stream_buffer: queue-based reference model, per-scenario tasks.
// Build with VOUT_STREAM_UNDERFLOW_CNT_EN defined to also check underflow_cnt.
module tb_vout_stream_buffer;

   localparam logic [23:0] FILL_C = 24'h108080;
   localparam int THRESH = 512 - 60;
   localparam int P_IDLE = 0, P_FLUSH = 1, P_FILL = 2, P_RUN = 3;
`ifdef VOUT_STREAM_UNDERFLOW_CNT_EN
   localparam int VW = 54;
`else
   localparam int VW = 38;
`endif

   logic        pixel_clk, rst_n, vs, in_valid, pixel_rd_req;
   logic [23:0] in_data;
   logic        in_ready, pixel_de, frame_ready, underflow;
   logic [23:0] pixel_data;
   logic [9:0]  fifo_level;
   logic [1:0]  dbg_state;
`ifdef VOUT_STREAM_UNDERFLOW_CNT_EN
   logic [15:0] underflow_cnt;
`endif

   vout_stream_buffer dut (
      .pixel_clk    (pixel_clk),
      .rst_n        (rst_n),
      .vs           (vs),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .pixel_rd_req (pixel_rd_req),
      .pixel_data   (pixel_data),
      .pixel_de     (pixel_de),
      .fifo_level   (fifo_level),
      .frame_ready  (frame_ready),
      .underflow    (underflow),
`ifdef VOUT_STREAM_UNDERFLOW_CNT_EN
      .underflow_cnt(underflow_cnt),
`endif
      .dbg_state    (dbg_state)
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   int checks = 0;
   int failures = 0;

   // Reference model: a word queue plus frame phase, advanced once per rising edge
   logic [23:0] m_fifo[$];
   int          m_phase = P_IDLE;
   logic        m_vs_prev = 1'b0, m_de = 1'b0, m_fr = 1'b0, m_uf = 1'b0, m_acc = 1'b0;
   logic [23:0] m_pix = FILL_C;
   logic [15:0] m_cnt = '0;

   task automatic model_step();
      int   sz;
      logic act, rdy, fs, wr, rd;
      if (!rst_n) begin
         m_fifo.delete();
         m_phase = P_IDLE; m_pix = FILL_C; m_de = 0; m_fr = 0; m_uf = 0;
         m_vs_prev = 0; m_acc = 0; m_cnt = '0;
      end else begin
         sz  = m_fifo.size();
         act = (m_phase == P_FILL) || (m_phase == P_RUN);
         rdy = act && (sz < THRESH);
         fs  = vs && !m_vs_prev;
         wr  = in_valid && rdy;
         rd  = pixel_rd_req && act && (sz > 0);
         m_de  = pixel_rd_req;
         m_acc = wr;
         if (rd) m_pix = m_fifo.pop_front();
         else begin
            m_pix = FILL_C;
            if (pixel_rd_req && m_phase == P_RUN) begin
               m_uf = 1;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
         end
         if (wr) m_fifo.push_back(in_data);
         if (fs) begin
            m_phase = P_FLUSH; m_fifo.delete(); m_uf = 0; m_cnt = '0; m_fr = 0;
         end else if (m_phase == P_FLUSH) m_phase = P_FILL;
         else if (m_phase == P_FILL && sz >= 32) begin
            m_phase = P_RUN; m_fr = 1;
         end
         m_vs_prev = vs;
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic rdy;
      rdy = ((m_phase == P_FILL) || (m_phase == P_RUN)) && (m_fifo.size() < THRESH);
`ifdef VOUT_STREAM_UNDERFLOW_CNT_EN
      return {rdy, 10'(m_fifo.size()), m_pix, m_de, m_fr, m_uf, m_cnt};
`else
      return {rdy, 10'(m_fifo.size()), m_pix, m_de, m_fr, m_uf};
`endif
   endfunction

   wire [VW-1:0] obs_vec = {in_ready, fifo_level, pixel_data, pixel_de, frame_ready, underflow
`ifdef VOUT_STREAM_UNDERFLOW_CNT_EN
                            , underflow_cnt
`endif
                           };

   // Inputs change on the falling edge; outputs are compared on the falling edge
   task automatic tick();
      @(posedge pixel_clk);
      model_step();
      @(negedge pixel_clk);
   endtask

   task automatic next_word();
      if (!in_valid || m_acc) in_data = 24'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 0; vs = 0; in_valid = 0; pixel_rd_req = 0; in_data = '0;
      for (int i = 0; i < 3; i++) begin
         pixel_rd_req = (i % 2 == 0);
         tick();
         checks++;
         if (pixel_data !== FILL_C || in_ready !== 1'b0 || fifo_level !== 10'd0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset pix=%h rdy=%b lvl=%0d uf=%b, want pix=%h rdy=0 lvl=0 uf=0",
                     pixel_data, in_ready, fifo_level, underflow, FILL_C);
         end
      end
      rst_n = 1; pixel_rd_req = 0;
      tick();
      checks++;
      if (obs_vec !== exp_vec()) begin
         failures++; $display("FAIL reset_release obs=%h exp=%h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_prefill();
      in_valid = 1; in_data = 24'($urandom); vs = 1;
      for (int i = 0; i < 45; i++) begin
         tick();
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++; $display("FAIL prefill cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
         end
         if (i == 0) begin
            checks++;
            if (in_ready !== 1'b0) begin
               failures++; $display("FAIL flush_ready got=%b want=0", in_ready);
            end
         end
         next_word();
      end
      checks++;
      if (frame_ready !== 1'b1) begin
         failures++; $display("FAIL prefill_frame_ready got=%b want=1", frame_ready);
      end
   endtask

   task automatic test_throttle();
      for (int i = 0; i < 430; i++) begin
         tick();
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++; $display("FAIL throttle cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
         end
         next_word();
      end
      checks++;
      if (fifo_level !== 10'd452 || in_ready !== 1'b0) begin
         failures++; $display("FAIL throttle_limit lvl=%0d rdy=%b want lvl=452 rdy=0", fifo_level, in_ready);
      end
      pixel_rd_req = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++; $display("FAIL throttle_drain cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
         end
         next_word();
      end
      pixel_rd_req = 0; in_valid = 0;
   endtask

   task automatic test_ordered();
      vs = 0; tick();
      vs = 1; tick();
      tick();
      for (int k = 1; k <= 16; k++) begin
         in_valid = 1; in_data = 24'(k);
         tick();
      end
      in_valid = 0;
      for (int k = 1; k <= 16; k++) begin
         pixel_rd_req = 1;
         tick();
         checks++;
         if (pixel_data !== 24'(k) || pixel_de !== 1'b1 || obs_vec !== exp_vec()) begin
            failures++;
            $display("FAIL ordered k=%0d pix=%h de=%b want pix=%h de=1 (obs=%h exp=%h)",
                     k, pixel_data, pixel_de, 24'(k), obs_vec, exp_vec());
         end
      end
      tick();
      checks++;
      if (pixel_data !== FILL_C || underflow !== 1'b0) begin
         failures++; $display("FAIL fill_empty_read pix=%h uf=%b want pix=%h uf=0", pixel_data, underflow, FILL_C);
      end
      pixel_rd_req = 0;
      tick();
      checks++;
      if (pixel_de !== 1'b0) begin
         failures++; $display("FAIL de_drop got=%b want=0", pixel_de);
      end
   endtask

   task automatic test_underflow();
      in_valid = 1;
      for (int i = 0; i < 40; i++) begin
         next_word();
         tick();
      end
      in_valid = 0;
      tick(); tick();
      for (int g = 0; g < 100 && m_fifo.size() > 0; g++) begin
         pixel_rd_req = 1;
         tick();
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++; $display("FAIL uf_drain obs=%h exp=%h", obs_vec, exp_vec());
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (pixel_data !== FILL_C || underflow !== 1'b1) begin
            failures++; $display("FAIL uf_read i=%0d pix=%h uf=%b want pix=%h uf=1", i, pixel_data, underflow, FILL_C);
         end
      end
      pixel_rd_req = 0;
      tick(); tick();
      checks++;
      if (underflow !== 1'b1 || frame_ready !== 1'b1) begin
         failures++; $display("FAIL uf_sticky uf=%b fr=%b want uf=1 fr=1", underflow, frame_ready);
      end
`ifdef VOUT_STREAM_UNDERFLOW_CNT_EN
      checks++;
      if (underflow_cnt !== 16'd3) begin
         failures++; $display("FAIL uf_cnt got=%0d want=3", underflow_cnt);
      end
`endif
      vs = 0; tick();
      vs = 1; tick();
      checks++;
      if (underflow !== 1'b0 || frame_ready !== 1'b0 || obs_vec !== exp_vec()) begin
         failures++; $display("FAIL uf_clear uf=%b fr=%b want 0 0 (obs=%h exp=%h)", underflow, frame_ready, obs_vec, exp_vec());
      end
   endtask

   task automatic test_mid_flush();
      logic [23:0] head;
      vs = 0; in_valid = 1;
      for (int g = 0; g < 300 && m_fifo.size() < 100; g++) begin
         next_word();
         tick();
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++; $display("FAIL mid_fill obs=%h exp=%h", obs_vec, exp_vec());
         end
      end
      checks++;
      if (fifo_level !== 10'd100) begin
         failures++; $display("FAIL mid_level got=%0d want=100", fifo_level);
      end
      head = m_fifo[0];
      next_word();
      vs = 1; pixel_rd_req = 1;
      tick();
      checks++;
      if (fifo_level !== 10'd0 || pixel_data !== head || in_ready !== 1'b0 || obs_vec !== exp_vec()) begin
         failures++;
         $display("FAIL mid_flush lvl=%0d pix=%h rdy=%b want lvl=0 pix=%h rdy=0", fifo_level, pixel_data, in_ready, head);
      end
      in_valid = 0; pixel_rd_req = 0;
      tick();
      checks++;
      if (in_ready !== 1'b1 || fifo_level !== 10'd0 || pixel_data !== FILL_C) begin
         failures++; $display("FAIL mid_fill_state rdy=%b lvl=%0d pix=%h want rdy=1 lvl=0 pix=%h", in_ready, fifo_level, pixel_data, FILL_C);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 249) == 0) vs = ~vs;
         if (!(in_valid && !m_acc)) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = 24'($urandom);
         end
         pixel_rd_req = $urandom_range(0, 1);
         tick();
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs_vec, exp_vec());
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_prefill();
      test_throttle();
      test_ordered();
      test_underflow();
      test_mid_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
